rggen_rc_irq_coalescer: RTL and testbench
=========================================

// Module: rggen_rc_irq_coalescer
// PURPOSE
//  Interrupt scheduler for a read-clear (RC) status bit field. Registers hardware events into set pulses for the RC field.
//  Coalesces them by event-count threshold or timeout, and raises o_irq until software read-clears the masked status.
//  A hold-off interval follows each clear. Sits between event sources and one RC field instance inside a register block.
// PARAMETERS
//  WIDTH        8   number of status bits / event lines
//  COUNT_WIDTH  8   width of coalescing event counter and i_threshold
//  TIMER_WIDTH  16  width of timeout/hold-off down-counter, i_timeout, i_holdoff
// PORTS
//  i_clk        in   1            clock
//  i_rst_n      in   1            asynchronous active-low reset
//  i_event      in   WIDTH        per-bit event requests (level; see CONFIGURATION)
//  i_enable     in   WIDTH        per-bit interrupt enable; also drives RC field mask
//  i_threshold  in   COUNT_WIDTH  event-cycle count that triggers irq (0 or 1 = first event)
//  i_timeout    in   TIMER_WIDTH  cycles from first event to forced irq; 0 = timeout disabled
//  i_holdoff    in   TIMER_WIDTH  quiet cycles after status clear before re-arm
//  i_value      in   WIDTH        RC field unmasked value (feedback)
//  o_set        out  WIDTH        set pulses to RC field i_set
//  o_mask       out  WIDTH        mask to RC field i_mask (= i_enable, combinational)
//  o_irq        out  1            interrupt request, registered
//  o_state      out  2            current FSM state, debug
// BEHAVIOUR
//  Reset: o_set=0, o_irq=0, counter=0, timer=0, state=IDLE. Asynchronous assertion mid-operation aborts everything to these values.
//  o_set <= ev & i_enable each cycle, one-cycle latency, in every state (events are never dropped).
//  status = i_value & i_enable; hit = (o_set != 0).
//  Counter increments by 1 per hit cycle in IDLE/COLLECT (not popcount) and saturates at all-ones.
//  States:
//   IDLE:     o_irq=0. On hit: counter=1, timer=i_timeout, go COLLECT.
//             If status!=0 without hit (enable newly set): counter=1, go COLLECT.
//   COLLECT:  timer decrements when i_timeout!=0, saturating at 0.
//             If counter>=i_threshold, or (i_timeout!=0 and timer==1), or i_threshold<=1: next ASSERT, o_irq<=1.
//             Else if status==0 and !hit: IDLE, counter cleared.
//   ASSERT:   o_irq=1, counter frozen. On status==0: o_irq<=0, timer=i_holdoff, go HOLDOFF.
//             A simultaneous hit is kept in the RC field and seen after hold-off.
//   HOLDOFF:  o_irq=0, timer decrements. i_holdoff=0 means one cycle. At timer<=1:
//             status!=0 -> COLLECT (counter=1, timer=i_timeout); else IDLE (counter=0).
//  Threshold change while COLLECT takes effect on the next compare. Enable clear removes bits from status immediately.
//  Clearing all enables in ASSERT drops to HOLDOFF the next cycle.
//  o_irq asserts exactly one cycle after the COLLECT cycle that meets the trigger.
// CONFIGURATION
//  RGGEN_RC_IRQ_COALESCER_EDGE_DETECT_EN defined: ev = i_event & ~event_q (rising-edge detect, event_q reset 0).
//   A held-high event sets its bit once.
//  Not defined: ev = i_event (level). A held-high event sets its bit every cycle and counts every cycle.
// STRUCTURE
//  Package rggen_rc_irq_pkg: typedef enum logic [1:0] {IDLE=0, COLLECT=1, ASSERT=2, HOLDOFF=3} rggen_rc_irq_state_e.
//  Sub-module rggen_rc_irq_timer: loadable saturating down-counter (i_load, i_load_value, i_dec, o_count, o_expire).
//   Shared by timeout and hold-off phases.
// TESTING
//  1 threshold=3, timeout=0: event bit0 pulses on 3 separate cycles -> o_set bit0 each +1, o_irq rises 1 cycle after 3rd hit.
//  2 threshold=10, timeout=5: single event -> o_irq at cycle 6 after o_set; clear i_value -> HOLDOFF, o_irq=0 next cycle.
//  3 holdoff=4: event during HOLDOFF -> o_set forwarded, no irq for 4 cycles, then COLLECT, irq per threshold.
//  4 enable=0x01, event=0x02 -> o_set=0, stays IDLE; then set enable=0x02 with i_value[1]=1 -> COLLECT.
//  5 reset asserted in ASSERT -> o_irq, o_set 0 immediately, state IDLE; no irq after release without new events.
//  6 macro on: i_event held high 8 cycles -> o_set one pulse, counter=1; macro off -> 8 pulses, counter=8.

Source files
------------

// File: rtl/rggen_rc_irq_pkg.sv
// rggen_rc_irq_pkg: shared types for the RC-field interrupt coalescer.
package rggen_rc_irq_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    ASSERT  = 2'd2,
    HOLDOFF = 2'd3
  } rggen_rc_irq_state_e;
endpackage

// File: rtl/rggen_rc_irq_timer.sv
// rggen_rc_irq_timer: loadable down-counter saturating at zero, shared by timeout and hold-off.
module rggen_rc_irq_timer #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  input  logic             i_dec,
  output logic [WIDTH-1:0] o_count,
  output logic             o_expire
);
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  always_comb begin
    count_d = i_load ? i_load_value :
              (i_dec && count_q != '0) ? count_q - WIDTH'(1) : count_q;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) count_q <= '0;
    else          count_q <= count_d;
  end
  assign o_count  = count_q;
  assign o_expire = count_q <= WIDTH'(1);
endmodule

// File: rtl/rggen_rc_irq_coalescer.sv
// rggen_rc_irq_coalescer: coalesces events into RC-field set pulses and a thresholded/timed irq.
// Define RGGEN_RC_IRQ_COALESCER_EDGE_DETECT_EN to set on rising edges of i_event instead of levels.
module rggen_rc_irq_coalescer
  import rggen_rc_irq_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int COUNT_WIDTH = 8,
  parameter int TIMER_WIDTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [WIDTH-1:0]       i_event,
  input  logic [WIDTH-1:0]       i_enable,
  input  logic [COUNT_WIDTH-1:0] i_threshold,
  input  logic [TIMER_WIDTH-1:0] i_timeout,
  input  logic [TIMER_WIDTH-1:0] i_holdoff,
  input  logic [WIDTH-1:0]       i_value,
  output logic [WIDTH-1:0]       o_set,
  output logic [WIDTH-1:0]       o_mask,
  output logic                   o_irq,
  output logic [1:0]             o_state
);
  rggen_rc_irq_state_e    state_q;
  logic [WIDTH-1:0]       set_q;
  logic [WIDTH-1:0]       ev;
  logic [COUNT_WIDTH-1:0] cnt_q;
  logic [COUNT_WIDTH-1:0] cnt_inc;
  logic                   irq_q;
  logic                   hit;
  logic                   status_nz;
  logic                   trig;
  logic                   tmr_load;
  logic                   tmr_dec;
  logic                   tmr_exp;
  logic [TIMER_WIDTH-1:0] tmr_val;
  logic [TIMER_WIDTH-1:0] tmr_cnt;
`ifdef RGGEN_RC_IRQ_COALESCER_EDGE_DETECT_EN
  logic [WIDTH-1:0] event_q;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) event_q <= '0;
    else          event_q <= i_event;
  end
  assign ev = i_event & ~event_q;
`else
  assign ev = i_event;
`endif
  // Threshold compare includes the hit of the current cycle so irq follows the triggering hit by one cycle.
  always_comb begin
    hit       = |set_q;
    status_nz = |(i_value & i_enable);
    cnt_inc   = &cnt_q ? cnt_q : cnt_q + COUNT_WIDTH'(1);
    trig      = ((hit ? cnt_inc : cnt_q) >= i_threshold) ||
                (i_timeout != '0 && tmr_cnt == TIMER_WIDTH'(1)) ||
                (i_threshold <= COUNT_WIDTH'(1));
    tmr_load  = (state_q == IDLE && (hit || status_nz)) ||
                (state_q == ASSERT && !status_nz) ||
                (state_q == HOLDOFF && tmr_exp && status_nz);
    tmr_val   = state_q == ASSERT ? i_holdoff : i_timeout;
    tmr_dec   = state_q == HOLDOFF || (state_q == COLLECT && i_timeout != '0);
  end
  rggen_rc_irq_timer #(.WIDTH(TIMER_WIDTH)) u_timer (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_load       (tmr_load),
    .i_load_value (tmr_val),
    .i_dec        (tmr_dec),
    .o_count      (tmr_cnt),
    .o_expire     (tmr_exp)
  );
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      set_q   <= '0;
      cnt_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      set_q <= ev & i_enable;
      case (state_q)
        IDLE: if (hit || status_nz) begin
          state_q <= COLLECT;
          cnt_q   <= COUNT_WIDTH'(1);
        end
        COLLECT: begin
          if (hit) cnt_q <= cnt_inc;
          if (trig) begin
            state_q <= ASSERT;
            irq_q   <= 1'b1;
          end else if (!status_nz && !hit) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        end
        ASSERT: if (!status_nz) begin
          state_q <= HOLDOFF;
          irq_q   <= 1'b0;
        end
        default: if (tmr_exp) begin
          state_q <= status_nz ? COLLECT : IDLE;
          cnt_q   <= status_nz ? COUNT_WIDTH'(1) : '0;
        end
      endcase
    end
  end
  assign o_set   = set_q;
  assign o_mask  = i_enable;
  assign o_irq   = irq_q;
  assign o_state = state_q;
endmodule

// File: tb/tb_rggen_rc_irq_coalescer.sv
// tb_rggen_rc_irq_coalescer: directed checks of the coalescer against a behavioural RC field.
module tb_rggen_rc_irq_coalescer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  ev = '0, en = '0, value, rd_clr = '0, inj = '0, set, mask;
  logic [7:0]  thr = '0;
  logic [15:0] tmo = '0, hold = '0;
  logic        irq;
  logic [1:0]  st;
  int errors = 0;
  int checks = 0;
  int pulses;
  always #5 clk = ~clk;
  rggen_rc_irq_coalescer dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_event     (ev),
    .i_enable    (en),
    .i_threshold (thr),
    .i_timeout   (tmo),
    .i_holdoff   (hold),
    .i_value     (value),
    .o_set       (set),
    .o_mask      (mask),
    .o_irq       (irq),
    .o_state     (st)
  );
  // RC field: sets win over a same-cycle read-clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) value <= '0;
    else        value <= (value & ~rd_clr) | set | inj;
  end
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic rd_clear();
    rd_clr = 8'hff;
    tick();
    rd_clr = 8'h00;
  endtask
  initial begin
    tick();
    check("rst_irq", irq, 0);
    check("rst_set", set, 0);
    check("rst_state", st, 0);
    rst_n = 1'b1;
    tick();
    // 1: threshold 3, no timeout
    en = 8'h01; thr = 8'd3; tmo = 0; hold = 0;
    ev = 8'h01; tick(); check("t1_set1", set, 8'h01);
    check("t1_mask", mask, 8'h01);
    ev = 8'h00; tick(); check("t1_collect", st, 1);
    ev = 8'h01; tick(); check("t1_set2", set, 8'h01);
    ev = 8'h00; tick(); check("t1_irq_lo2", irq, 0);
    ev = 8'h01; tick(); check("t1_set3", set, 8'h01);
    check("t1_irq_lo3", irq, 0);
    ev = 8'h00; tick(); check("t1_irq", irq, 1);
    check("t1_assert", st, 2);
    rd_clear();
    check("t1_still_assert", st, 2);
    tick(); check("t1_holdoff", st, 3);
    check("t1_irq_off", irq, 0);
    tick(); check("t1_idle", st, 0);
    // 2: timeout 5 with high threshold
    thr = 8'd10; tmo = 16'd5; hold = 16'd2;
    ev = 8'h01; tick(); check("t2_set", set, 8'h01);
    ev = 8'h00;
    for (int i = 0; i < 5; i++) begin
      tick(); check("t2_irq_wait", irq, 0);
    end
    tick(); check("t2_irq", irq, 1);
    rd_clear();
    tick(); check("t2_irq_off", irq, 0);
    check("t2_holdoff", st, 3);
    tick(); check("t2_holdoff2", st, 3);
    tick(); check("t2_idle", st, 0);
    // 3: event during a 4-cycle hold-off
    thr = 8'd2; tmo = 0; hold = 16'd4;
    ev = 8'h01; tick(); ev = 8'h00; tick();
    ev = 8'h01; tick(); ev = 8'h00; tick();
    check("t3_irq", irq, 1);
    rd_clear();
    tick(); check("t3_holdoff", st, 3);
    ev = 8'h01; tick(); check("t3_set_fwd", set, 8'h01);
    ev = 8'h00;
    for (int i = 0; i < 2; i++) begin
      check("t3_hold_state", st, 3);
      check("t3_hold_irq", irq, 0);
      tick();
    end
    check("t3_hold_last", st, 3);
    tick(); check("t3_collect", st, 1);
    check("t3_no_irq", irq, 0);
    ev = 8'h01; tick(); ev = 8'h00; tick();
    check("t3_irq2", irq, 1);
    rd_clear();
    repeat (5) tick();
    check("t3_idle", st, 0);
    // 4: disabled event, then enabling a pending status bit
    en = 8'h01; thr = 8'd3; hold = 0;
    ev = 8'h02; tick(); check("t4_set_masked", set, 0);
    ev = 8'h00; tick(); check("t4_idle", st, 0);
    inj = 8'h02; tick(); inj = 8'h00;
    check("t4_idle2", st, 0);
    en = 8'h02; check("t4_mask", mask, 8'h02);
    tick(); check("t4_collect", st, 1);
    check("t4_set0", set, 0);
    thr = 8'd1; tick(); check("t4_thr1_irq", irq, 1);
    en = 8'h00; tick(); check("t4_en_clr_holdoff", st, 3);
    check("t4_en_clr_irq", irq, 0);
    tick(); check("t4_idle3", st, 0);
    // 5: asynchronous reset while asserting
    en = 8'h01; thr = 8'd1;
    ev = 8'h01; tick(); ev = 8'h00; tick(); tick();
    check("t5_irq", irq, 1);
    ev = 8'h01; tick(); ev = 8'h00;
    check("t5_set_pre", set, 8'h01);
    #2 rst_n = 1'b0;
    #1 check("t5_rst_irq", irq, 0);
    check("t5_rst_set", set, 0);
    check("t5_rst_state", st, 0);
    tick(); rst_n = 1'b1;
    repeat (5) tick();
    check("t5_post_irq", irq, 0);
    check("t5_post_state", st, 0);
    // 6: event held high for 8 cycles
    thr = 8'd20; tmo = 0; pulses = 0;
    ev = 8'h01;
    repeat (8) begin
      tick(); if (set[0]) pulses++;
    end
    ev = 8'h00;
    repeat (3) begin
      tick(); if (set[0]) pulses++;
    end
    check("t6_state", st, 1);
`ifdef RGGEN_RC_IRQ_COALESCER_EDGE_DETECT_EN
    check("t6_pulses", pulses, 1);
    check("t6_count", dut.cnt_q, 1);
`else
    check("t6_pulses", pulses, 8);
    check("t6_count", dut.cnt_q, 8);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
